// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared dmem widths and arbiter state encoding
// Contents: DMEM_DATA_W, DMEM_ADDR_W, dmem_state_e (IDLE/ACCESS/RESP).
package dmem_pkg;

    localparam int DMEM_DATA_W = 48;
    localparam int DMEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
// Ports:
//   req[1:0]   in   request vector, bit N = port N
//   last_grant in   port that won the previous handshake
//   grant[1:0] out  one-hot winner, or zero when nothing requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the port that did not win last time goes first.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing single-port dmem between cpu and loader
// Optional build macro: DMEM_ARB_PERF_EN adds perf_grant0/perf_grant1/perf_conflict counters.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   pN_valid/pN_ready               request handshake for port N (0 = cpu, 1 = debug/loader)
//   pN_we/pN_addr/pN_wdata          request payload, held stable until ready
//   pN_resp_valid/pN_rdata          one-cycle response pulse and read data (0 for writes)
//   mem_en/mem_we/mem_addr/mem_wdata registered memory pins
//   mem_rdata                       memory read data, valid the cycle after mem_en
//   perf_grant0/perf_grant1/perf_conflict (DMEM_ARB_PERF_EN only) saturating 16-bit counters
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_grant0,
    output logic [15:0]       perf_grant1,
    output logic [15:0]       perf_conflict
`endif
);

    dmem_state_e state, state_next;
    logic        last_grant;
    logic        owner;
    logic        resp_we;
    logic [1:0]  grant;
    logic        hs;
    logic        hs_port;

    rr_arb2 u_rr_arb2 (
        .req        ({p1_valid, p0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        p0_ready      = 1'b0;
        p1_ready      = 1'b0;
        p0_resp_valid = 1'b0;
        p1_resp_valid = 1'b0;
        p0_rdata      = '0;
        p1_rdata      = '0;
        hs            = 1'b0;
        hs_port       = 1'b0;
        case (state)
            IDLE: begin
                // Gated by reset so ready reads 0 while reset is held.
                p0_ready = grant[0] & reset;
                p1_ready = grant[1] & reset;
                hs       = p0_ready | p1_ready;
                hs_port  = grant[1];
                if (hs) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                if (owner) begin
                    p1_resp_valid = 1'b1;
                    p1_rdata      = resp_we ? '0 : mem_rdata;
                end else begin
                    p0_resp_valid = 1'b1;
                    p0_rdata      = resp_we ? '0 : mem_rdata;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory pins are loaded on the handshake edge so the strobe is high
    // exactly for the ACCESS cycle; addr/wdata keep their last value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            resp_we    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (hs) begin
                last_grant <= hs_port;
                owner      <= hs_port;
                resp_we    <= hs_port ? p1_we : p0_we;
                mem_en     <= 1'b1;
                mem_we     <= hs_port ? p1_we : p0_we;
                mem_addr   <= hs_port ? p1_addr : p0_addr;
                mem_wdata  <= hs_port ? p1_wdata : p0_wdata;
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (hs && !hs_port && perf_grant0 != 16'hFFFF) begin
                perf_grant0 <= perf_grant0 + 16'd1;
            end
            if (hs && hs_port && perf_grant1 != 16'hFFFF) begin
                perf_grant1 <= perf_grant1 + 16'd1;
            end
            if (state == IDLE && p0_valid && p1_valid && perf_conflict != 16'hFFFF) begin
                perf_conflict <= perf_conflict + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int DW = 48;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          p0_valid = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_valid = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p0_ready, p0_resp_valid, p1_ready, p1_resp_valid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0]   perf_grant0, perf_grant1, perf_conflict;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dmem_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .p0_valid      (p0_valid),
        .p0_ready      (p0_ready),
        .p0_we         (p0_we),
        .p0_addr       (p0_addr),
        .p0_wdata      (p0_wdata),
        .p0_resp_valid (p0_resp_valid),
        .p0_rdata      (p0_rdata),
        .p1_valid      (p1_valid),
        .p1_ready      (p1_ready),
        .p1_we         (p1_we),
        .p1_addr       (p1_addr),
        .p1_wdata      (p1_wdata),
        .p1_resp_valid (p1_resp_valid),
        .p1_rdata      (p1_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port memory: read data appears the cycle after mem_en.
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one unit after a rising edge; leaves the same way, back in IDLE.
    task automatic xact(input string tag, input bit p, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd);
        bit got;
        if (p) begin
            p1_valid = 1'b1; p1_we = we; p1_addr = a; p1_wdata = wd;
        end else begin
            p0_valid = 1'b1; p0_we = we; p0_addr = a; p0_wdata = wd;
        end
        #1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if ((p ? p1_ready : p0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick();
            #1;
        end
        check({tag, "_ready"}, {47'd0, got}, 48'd1);
        tick();
        if (p) p1_valid = 1'b0; else p0_valid = 1'b0;
        check({tag, "_mem_en"}, {47'd0, mem_en}, 48'd1);
        check({tag, "_mem_we"}, {47'd0, mem_we}, {47'd0, we});
        check({tag, "_mem_addr"}, {38'd0, mem_addr}, {38'd0, a});
        tick();
        check({tag, "_resp"}, {47'd0, (p ? p1_resp_valid : p0_resp_valid)}, 48'd1);
        check({tag, "_other_resp"}, {47'd0, (p ? p0_resp_valid : p1_resp_valid)}, 48'd0);
        check({tag, "_rdata"}, (p ? p1_rdata : p0_rdata), exp_rd);
        check({tag, "_other_rdata"}, (p ? p0_rdata : p1_rdata), 48'd0);
        tick();
        check({tag, "_resp_drop"}, {47'd0, (p ? p1_resp_valid : p0_resp_valid)}, 48'd0);
    endtask

    initial begin
        int last_hs;
        bit exp_p;

        // Reset state with both requesters already asserting valid.
        p0_valid = 1'b1;
        p1_valid = 1'b1;
        #2;
        check("rst_p0_ready", {47'd0, p0_ready}, 48'd0);
        check("rst_p1_ready", {47'd0, p1_ready}, 48'd0);
        check("rst_mem_en", {47'd0, mem_en}, 48'd0);
        check("rst_mem_we", {47'd0, mem_we}, 48'd0);
        check("rst_mem_addr", {38'd0, mem_addr}, 48'd0);
        check("rst_mem_wdata", mem_wdata, 48'd0);
        check("rst_p0_resp", {47'd0, p0_resp_valid}, 48'd0);
        check("rst_p1_resp", {47'd0, p1_resp_valid}, 48'd0);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        #20;
        reset = 1'b1;
        tick();

        // Loader writes, cpu reads back.
        xact("p1_wr16", 1'b1, 1'b1, 10'd16, 48'd20, 48'd0);
        xact("p1_wr32", 1'b1, 1'b1, 10'd32, 48'd22, 48'd0);
        check("mem16", mem[16], 48'd20);
        check("mem32", mem[32], 48'd22);
        xact("p0_rd16", 1'b0, 1'b0, 10'd16, 48'd0, 48'd20);
        xact("p0_rd32", 1'b0, 1'b0, 10'd32, 48'd0, 48'd22);

        // Write from cpu, read back through loader.
        xact("p0_wr48", 1'b0, 1'b1, 10'd48, 48'd42, 48'd0);
        xact("p1_rd48", 1'b1, 1'b0, 10'd48, 48'd0, 48'd42);

        // Continuous contention after a fresh reset: p0, p1, p0, p1, ...
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 10'd48;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 10'd48;
        #1;
        last_hs = 0;
        for (int k = 0; k < 8; k++) begin
            exp_p = k[0];
            check("con_win_ready", {47'd0, (exp_p ? p1_ready : p0_ready)}, 48'd1);
            check("con_lose_ready", {47'd0, (exp_p ? p0_ready : p1_ready)}, 48'd0);
            tick();
            if (k > 0) check("con_spacing", 48'(cyc - last_hs), 48'd3);
            last_hs = cyc;
            if (k == 7) begin
                p0_valid = 1'b0;
                p1_valid = 1'b0;
            end
            check("con_acc_ready", {46'd0, p1_ready, p0_ready}, 48'd0);
            tick();
            check("con_resp_ready", {46'd0, p1_ready, p0_ready}, 48'd0);
            check("con_resp_owner", {46'd0, p1_resp_valid, p0_resp_valid},
                  exp_p ? 48'd2 : 48'd1);
            check("con_rdata", (exp_p ? p1_rdata : p0_rdata), 48'd42);
            tick();
            #1;
        end
`ifdef DMEM_ARB_PERF_EN
        check("perf_grant0", {32'd0, perf_grant0}, 48'd4);
        check("perf_grant1", {32'd0, perf_grant1}, 48'd4);
        check("perf_conflict_ge4", {47'd0, (perf_conflict >= 16'd4)}, 48'd1);
`endif

        // Reset during ACCESS of a cpu write: abandoned, memory untouched.
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 10'd48; p0_wdata = 48'd99;
        #1;
        check("mid_p0_ready", {47'd0, p0_ready}, 48'd1);
        tick();
        p0_valid = 1'b0;
        check("mid_mem_en_pre", {47'd0, mem_en}, 48'd1);
        reset = 1'b0;
        #1;
        check("mid_mem_en_async", {47'd0, mem_en}, 48'd0);
        check("mid_mem_we_async", {47'd0, mem_we}, 48'd0);
        check("mid_resp_async", {46'd0, p1_resp_valid, p0_resp_valid}, 48'd0);
        tick();
        reset = 1'b1;
        check("mid_mem_keep", mem[48], 48'd42);
        tick();
        check("mid_no_resp_a", {46'd0, p1_resp_valid, p0_resp_valid}, 48'd0);
        tick();
        check("mid_no_resp_b", {46'd0, p1_resp_valid, p0_resp_valid}, 48'd0);
        p0_valid = 1'b1; p0_we = 1'b0;
        p1_valid = 1'b1; p1_we = 1'b0;
        #1;
        check("post_rst_tie_p0", {47'd0, p0_ready}, 48'd1);
        check("post_rst_tie_p1", {47'd0, p1_ready}, 48'd0);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
